// File: rtl/vscale_imm_unit.sv
// RV immediate extractor with a small tagged output FIFO and valid/ready on both sides.
// Optional branch/jump target adder is built when VSCALE_IMM_TARGET_EN is defined.
module vscale_imm_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
`ifdef VSCALE_IMM_TARGET_EN
    input  logic [XLEN-1:0]  in_pc,
    output logic [XLEN-1:0]  out_target,
`endif
    output logic             out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      raw_imm;
    logic             dec_illegal;
    logic [XLEN-1:0]  dec_imm;

    logic [XLEN-1:0]  mem_imm [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic             mem_ill [DEPTH];
    logic [XLEN-1:0]  hold_imm;
    logic [TAG_W-1:0] hold_tag;
    logic             hold_ill;
`ifdef VSCALE_IMM_TARGET_EN
    logic [XLEN-1:0]  dec_target;
    logic [XLEN-1:0]  mem_tgt [DEPTH];
    logic [XLEN-1:0]  hold_tgt;
`endif

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;

    // Every format is formed as 32 bits with bit 31 carrying the sign, so a signed
    // widening gives XLEN=64 for free; zimm has bit 31 clear and thus zero-extends.
    always_comb begin
        raw_imm     = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_illegal = 1'b0;
        case (in_type)
            3'd0: raw_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            3'd1: raw_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            3'd2: raw_imm = {in_inst[31:12], 12'b0};
            3'd3: raw_imm = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
            3'd4: raw_imm = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
            3'd5: raw_imm = {27'b0, in_inst[19:15]};
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_imm = XLEN'($signed(raw_imm));
`ifdef VSCALE_IMM_TARGET_EN
    assign dec_target = in_pc + dec_imm;
`endif

    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Hold registers keep the last head visible once the FIFO drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold_imm <= '0;
            hold_tag <= '0;
            hold_ill <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm[i] <= '0;
                mem_tag[i] <= '0;
                mem_ill[i] <= 1'b0;
`ifdef VSCALE_IMM_TARGET_EN
                mem_tgt[i] <= '0;
`endif
            end
`ifdef VSCALE_IMM_TARGET_EN
            hold_tgt <= '0;
`endif
        end else begin
            if (out_valid) begin
                hold_imm <= mem_imm[rd_ptr];
                hold_tag <= mem_tag[rd_ptr];
                hold_ill <= mem_ill[rd_ptr];
`ifdef VSCALE_IMM_TARGET_EN
                hold_tgt <= mem_tgt[rd_ptr];
`endif
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    mem_imm[wr_ptr] <= dec_imm;
                    mem_tag[wr_ptr] <= in_tag;
                    mem_ill[wr_ptr] <= dec_illegal;
`ifdef VSCALE_IMM_TARGET_EN
                    mem_tgt[wr_ptr] <= dec_target;
`endif
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (pop && !push)
                    count <= count - CNT_W'(1);
            end
        end
    end

    assign out_imm     = out_valid ? mem_imm[rd_ptr] : hold_imm;
    assign out_tag     = out_valid ? mem_tag[rd_ptr] : hold_tag;
    assign out_illegal = out_valid ? mem_ill[rd_ptr] : hold_ill;
`ifdef VSCALE_IMM_TARGET_EN
    assign out_target  = out_valid ? mem_tgt[rd_ptr] : hold_tgt;
`endif

endmodule

// File: tb/tb_vscale_imm_unit.sv
// Drives a 32-bit and a 64-bit immediate unit in lockstep and compares both
// against a field-arithmetic reference model with a FIFO scoreboard.
module tb_vscale_imm_unit;

    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    typedef struct {
        longint     imm;
        logic [4:0] tag;
        logic       ill;
        longint     tgt;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_type;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_ready;
    logic [63:0] pc;

    logic        rdy32, vld32, ill32;
    logic [31:0] imm32;
    logic [4:0]  tag32;
    logic        rdy64, vld64, ill64;
    logic [63:0] imm64;
    logic [4:0]  tag64;
`ifdef VSCALE_IMM_TARGET_EN
    logic [31:0] tgt32;
    logic [63:0] tgt64;
`endif

    int     checks = 0;
    int     errors = 0;
    entry_t q[$];

    vscale_imm_unit #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .flush(flush),
        .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32),
`ifdef VSCALE_IMM_TARGET_EN
        .in_pc(pc[31:0]), .out_target(tgt32),
`endif
        .out_illegal(ill32));

    vscale_imm_unit #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag), .flush(flush),
        .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64),
`ifdef VSCALE_IMM_TARGET_EN
        .in_pc(pc), .out_target(tgt64),
`endif
        .out_illegal(ill64));

    always #5 clk = ~clk;

    // Immediate value as a signed integer, built from the ISA field layout.
    function automatic longint model_imm(input logic [31:0] inst, input logic [2:0] t);
        longint u, v;
        u = longint'(inst);
        case (t)
            3'd1: begin v = ((u >> 25) << 5) + ((u >> 7) & 31); if (v >= 2048) v -= 4096; end
            3'd2: begin v = u & 64'hFFFFF000; if (v >= 64'h80000000) v -= 64'h100000000; end
            3'd3: begin
                v = ((u >> 31) << 20) + (((u >> 12) & 255) << 12) + (((u >> 20) & 1) << 11)
                    + (((u >> 21) & 1023) << 1);
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            3'd4: begin
                v = ((u >> 31) << 12) + (((u >> 7) & 1) << 11) + (((u >> 25) & 63) << 5)
                    + (((u >> 8) & 15) << 1);
                if (v >= 4096) v -= 8192;
            end
            3'd5: v = (u >> 15) & 31;
            default: begin v = u >> 20; if (v >= 2048) v -= 4096; end
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [2:0] t,
                                 input logic [4:0] tag, input logic rdy, input logic fl,
                                 input logic [63:0] p);
        in_valid  = v;
        in_inst   = inst;
        in_type   = t;
        in_tag    = tag;
        out_ready = rdy;
        flush     = fl;
        pc        = p;
    endtask

    task automatic checkOutput();
        chk("valid32", {63'b0, vld32}, {63'b0, q.size() != 0});
        chk("valid64", {63'b0, vld64}, {63'b0, q.size() != 0});
        chk("ready32", {63'b0, rdy32}, {63'b0, q.size() < DEPTH});
        chk("ready64", {63'b0, rdy64}, {63'b0, q.size() < DEPTH});
        if (q.size() != 0) begin
            chk("imm32", {32'b0, imm32}, {32'b0, q[0].imm[31:0]});
            chk("imm64", imm64, q[0].imm);
            chk("tag32", {59'b0, tag32}, {59'b0, q[0].tag});
            chk("tag64", {59'b0, tag64}, {59'b0, q[0].tag});
            chk("ill32", {63'b0, ill32}, {63'b0, q[0].ill});
            chk("ill64", {63'b0, ill64}, {63'b0, q[0].ill});
`ifdef VSCALE_IMM_TARGET_EN
            chk("tgt32", {32'b0, tgt32}, {32'b0, q[0].tgt[31:0]});
            chk("tgt64", tgt64, q[0].tgt);
`endif
        end
    endtask

    // Check the current state, advance the scoreboard as the DUT should, then
    // move to the next falling edge.
    task automatic run_cycle();
        entry_t e;
        int     pre;
        checkOutput();
        pre = q.size();
        if (flush) begin
            q.delete();
        end else begin
            if (out_ready && pre > 0) void'(q.pop_front());
            if (in_valid && pre < DEPTH) begin
                e.imm = model_imm(in_inst, in_type);
                e.tag = in_tag;
                e.ill = (in_type >= 3'd6);
                e.tgt = longint'(pc) + e.imm;
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0, 64'h0);
        reset_n = 1'b0;
        #12;
        chk("rst_imm64", imm64, 64'h0);
        chk("rst_tag32", {59'b0, tag32}, 64'h0);
        chk("rst_ill32", {63'b0, ill32}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_cycle();

        // Individual formats, consumer always ready
        applyStimulus(1'b1, 32'hFFF00093, 3'd0, 5'd3, 1'b1, 1'b0, 64'h0);
        run_cycle();
        chk("i_latency", {63'b0, vld32}, 64'h1);
        chk("i_imm32", {32'b0, imm32}, 64'hFFFFFFFF);
        chk("i_tag", {59'b0, tag32}, 64'd3);
        applyStimulus(1'b1, 32'hFE112E23, 3'd1, 5'd4, 1'b1, 1'b0, 64'h0);
        run_cycle();
        chk("s_imm32", {32'b0, imm32}, 64'hFFFFFFFC);
        applyStimulus(1'b1, 32'hFE000CE3, 3'd4, 5'd5, 1'b1, 1'b0, 64'h1000);
        run_cycle();
        chk("b_imm32", {32'b0, imm32}, 64'hFFFFFFF8);
`ifdef VSCALE_IMM_TARGET_EN
        chk("b_tgt32", {32'b0, tgt32}, 64'h00000FF8);
`endif
        applyStimulus(1'b1, 32'h800000B7, 3'd2, 5'd6, 1'b1, 1'b0, 64'h0);
        run_cycle();
        chk("u_imm64", imm64, 64'hFFFFFFFF80000000);
        applyStimulus(1'b1, 32'h000FD073, 3'd5, 5'd7, 1'b1, 1'b0, 64'h0);
        run_cycle();
        chk("z_imm64", imm64, 64'h1F);
        applyStimulus(1'b1, 32'h00100093, 3'd7, 5'd8, 1'b1, 1'b0, 64'h0);
        run_cycle();
        chk("rsv_imm64", imm64, 64'h1);
        chk("rsv_ill", {63'b0, ill64}, 64'h1);
        applyStimulus(1'b1, 32'h00800093, 3'd0, 5'd9, 1'b1, 1'b0, 64'hFFFFFFFC);
        run_cycle();
`ifdef VSCALE_IMM_TARGET_EN
        chk("wrap_tgt32", {32'b0, tgt32}, 64'h4);
`endif
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 64'h0);
        run_cycle();

        // Backpressure: third request is held until space frees up
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h12345013 + 32'(i << 20), 3'd0, 5'(10 + i), 1'b0, 1'b0, 64'h0);
            run_cycle();
        end
        chk("full_ready", {63'b0, rdy32}, 64'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'h12545013, 3'd0, 5'd12, 1'b1, 1'b0, 64'h0);
            run_cycle();
        end
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 64'h0);
        run_cycle();
        run_cycle();

        // Flush with a simultaneous push that must be ignored
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'hABCDE037, 3'd2, 5'(20 + i), 1'b0, 1'b0, 64'h0);
            run_cycle();
        end
        applyStimulus(1'b1, 32'h00000013, 3'd0, 5'd22, 1'b1, 1'b1, 64'h0);
        run_cycle();
        chk("flush_valid", {63'b0, vld64}, 64'h0);
        chk("flush_ready", {63'b0, rdy64}, 64'h1);

        // Asynchronous reset mid-cycle while full
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'hFFFFF06F, 3'd3, 5'(24 + i), 1'b0, 1'b0, 64'h0);
            run_cycle();
        end
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b0, 1'b0, 64'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", {63'b0, vld32}, 64'h0);
        chk("arst_ready", {63'b0, rdy64}, 64'h1);
        chk("arst_imm64", imm64, 64'h0);
        chk("arst_tag64", {59'b0, tag64}, 64'h0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        run_cycle();

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), $urandom(), 3'($urandom_range(0, 7)),
                          5'($urandom()), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 24) == 0), {$urandom(), $urandom()});
            run_cycle();
        end
        applyStimulus(1'b0, 32'h0, 3'd0, 5'd0, 1'b1, 1'b0, 64'h0);
        run_cycle();
        run_cycle();
        run_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
